weight_reg_bank: RTL
====================

# weight_reg_bank

Parametrised, double-buffered weight/parameter register bank for the pedometer classifier datapath. It holds the threshold, beta and alpha weights plus the total-step count. A host loads new weights into a shadow bank through two write ports, then commits only the changed entries to the active bank atomically. The active bank drives the classifier continuously, and a dedicated saturating increment port maintains the step counter. A sequenced clear operation zeroes both banks.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 8, number of entries (≥2)
- ADDR_W, $clog2(DEPTH), address width
- STEP_IDX, 6, index of the step-count entry (< DEPTH)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr_valid_a / wr_valid_b  in  1  write request, port A / B
- wr_addr_a / wr_addr_b  in  ADDR_W  write address
- wr_data_a / wr_data_b  in  DATA_W  write data
- wr_ready  out  1  writes accepted when high (shared by both ports)
- commit  in  1  pulse: copy dirty shadow entries to active
- commit_done  out  1  one-cycle pulse after a commit executes
- step_inc  in  1  increment active[STEP_IDX], saturating
- clear  in  1  pulse: start a clear sweep
- clear_done  out  1  one-cycle pulse when the sweep finishes
- busy  out  1  clear sweep in progress
- rd_addr  in  ADDR_W  read address
- rd_sel  in  1  0 = active bank, 1 = shadow bank
- rd_data  out  DATA_W  registered read data
- active_flat  out  DEPTH*DATA_W  active bank, entry i at bits [i*DATA_W +: DATA_W]
- step_count  out  DATA_W  equals active[STEP_IDX]
- dirty  out  DEPTH  per-entry shadow-modified flags

## Operation
- States: IDLE and CLEAR. A 2-state FSM plus an ADDR_W sweep counter.
- Reset: all shadow and active entries, dirty, rd_data, commit_done and clear_done go to 0. State goes to IDLE and busy to 0. Reset overrides every other input, including a reset mid-clear.
- wr_ready = (state == IDLE) && !reset.
- Writes:
  - A write on port A or B is accepted when wr_valid_x && wr_ready.
  - An accepted write updates shadow[addr] and sets dirty[addr].
  - If both ports target the same address in the same cycle, port B's data wins.
  - Writes never modify the active bank directly.
- Commit (IDLE only):
  - For every i with dirty[i]=1, active[i] ← shadow[i] and dirty[i] ← 0. Clean entries are untouched.
  - Commit samples the shadow and dirty values from before the edge. A write in the same cycle lands in shadow, stays dirty, and is not included in this commit.
  - commit_done pulses in the following cycle. commit_done also pulses when no entry is dirty.
- step_inc (IDLE only): active[STEP_IDX] ← active[STEP_IDX]+1, saturating at 2^DATA_W−1.
  - If the same cycle's commit copies STEP_IDX (dirty), the commit value wins and the increment is lost.
  - If STEP_IDX is clean, both operations apply: other entries commit and the step increments.
- Clear:
  - A clear in IDLE enters CLEAR with counter = 0.
  - Each CLEAR cycle zeroes shadow[cnt], active[cnt] and dirty[cnt], then increments cnt.
  - After entry DEPTH−1 is cleared, the block returns to IDLE.
  - clear in CLEAR is ignored. If clear and commit arrive in the same IDLE cycle, clear wins and the commit is dropped with no commit_done.
- In CLEAR, the block ignores commit, step_inc and writes (wr_ready=0).
- Read:
  - rd_data ← (rd_sel ? shadow : active)[rd_addr] on every edge.
  - An out-of-range address (≥DEPTH) returns 0.
  - A write to an out-of-range address is dropped.

## Timing
- Write → shadow/dirty visible at the next edge. The rd port adds 1 more cycle.
- Commit at edge N → active_flat/step_count updated after edge N. commit_done is high during cycle N+1.
- step_inc at edge N → step_count updated after edge N (1-cycle latency).
- Clear sampled at edge N:
  - busy is high from after N through edge N+DEPTH.
  - Entry k is zeroed at edge N+1+k.
  - clear_done is high for the one cycle after edge N+DEPTH, in IDLE with wr_ready=1.
- All outputs are registered except wr_ready, busy, active_flat and step_count, which are direct state decodes.

## Test plan
- Reset, write A addr2=0x55 and B addr4=0xAA, then commit → dirty=0x14 before commit; active[2]=0x55, active[4]=0xAA, dirty=0 and commit_done pulse after.
- Both ports write addr1 (A=0x11, B=0x22), then commit → active[1]=0x22. A write of 0x33 to addr3 in the commit cycle leaves active[3]=0 and dirty[3]=1.
- 260 step_inc pulses with DATA_W=8 → step_count saturates at 0xFF. A dirty STEP_IDX=0x10 committed with step_inc in the same cycle → step_count=0x10.
- Fill all entries and commit, then clear → busy high 8 cycles, wr_ready low, and a write attempted during the sweep is dropped. clear_done pulse follows; all entries read 0 on both rd_sel values.
- Reset asserted 3 cycles into a clear → IDLE, busy=0, all zero, no clear_done.
- Parameter sweep DATA_W=16, DEPTH=12, STEP_IDX=11 → step increments saturate at 0xFFFF, and a read of addr 13 returns 0.

Source files
------------

// File: rtl/weight_reg_bank_if.sv
// Write-side bus of the weight register bank: two independent write ports
// sharing a single ready, driven by the host (master) into the bank (slave).
interface weight_reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_valid_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [DATA_W-1:0] wr_data_a;
    logic              wr_valid_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] wr_data_b;
    logic              wr_ready;

    modport master (
        output wr_valid_a, wr_addr_a, wr_data_a,
        output wr_valid_b, wr_addr_b, wr_data_b,
        input  wr_ready
    );

    modport slave (
        input  wr_valid_a, wr_addr_a, wr_data_a,
        input  wr_valid_b, wr_addr_b, wr_data_b,
        output wr_ready
    );
endinterface

// File: rtl/weight_reg_bank.sv
// Double-buffered weight bank: host writes land in a shadow bank, commit copies
// dirty entries to the active bank, clear sweeps both banks to zero.
module weight_reg_bank #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int STEP_IDX = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    weight_reg_bank_if.slave        wr,
    input  logic                    commit,
    output logic                    commit_done,
    input  logic                    step_inc,
    input  logic                    clear,
    output logic                    clear_done,
    output logic                    busy,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_sel,
    output logic [DATA_W-1:0]       rd_data,
    output logic [DEPTH*DATA_W-1:0] active_flat,
    output logic [DATA_W-1:0]       step_count,
    output logic [DEPTH-1:0]        dirty
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] active [DEPTH];

    logic              ready;
    logic              accept_a;
    logic              accept_b;
    logic              step_lost;
    logic [DATA_W-1:0] step_next;
    logic [DATA_W-1:0] rd_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    assign ready       = (state == IDLE) && !reset;
    assign wr.wr_ready = ready;
    assign busy        = (state == CLEAR);
    assign step_count  = active[STEP_IDX];

    assign accept_a = wr.wr_valid_a && ready && in_range(wr.wr_addr_a);
    assign accept_b = wr.wr_valid_b && ready && in_range(wr.wr_addr_b);

    // A commit that copies a dirty step entry overrides the same-cycle increment.
    assign step_lost = commit && !clear && dirty[STEP_IDX];
    assign step_next = (active[STEP_IDX] == '1) ? active[STEP_IDX]
                                                : active[STEP_IDX] + 1'b1;

    always_comb begin
        rd_word = '0;
        if (in_range(rd_addr)) begin
            rd_word = rd_sel ? shadow[rd_addr] : active[rd_addr];
        end
    end

    always_comb begin
        active_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            active_flat[i*DATA_W +: DATA_W] = active[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dirty       <= '0;
            rd_data     <= '0;
            commit_done <= 1'b0;
            clear_done  <= 1'b0;
            // NOTE: both banks are flops, not RAM, so they can and must reset to zero.
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit_done <= 1'b0;
            clear_done  <= 1'b0;
            rd_data     <= rd_word;

            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (commit) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (dirty[i]) begin
                                active[i] <= shadow[i];
                                dirty[i]  <= 1'b0;
                            end
                        end
                        commit_done <= 1'b1;
                    end

                    if (step_inc && !step_lost) begin
                        active[STEP_IDX] <= step_next;
                    end

                    // NOTE: later non-blocking writes win, so port B overrides A on a
                    // shared address and a fresh write re-dirties a committed entry.
                    if (accept_a) begin
                        shadow[wr.wr_addr_a] <= wr.wr_data_a;
                        dirty[wr.wr_addr_a]  <= 1'b1;
                    end
                    if (accept_b) begin
                        shadow[wr.wr_addr_b] <= wr.wr_data_b;
                        dirty[wr.wr_addr_b]  <= 1'b1;
                    end
                end

                CLEAR: begin
                    shadow[cnt] <= '0;
                    active[cnt] <= '0;
                    dirty[cnt]  <= 1'b0;
                    if (cnt == LAST_IDX) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
